// File: rtl/fsm_sched_pkg.sv
// fsm_sched_pkg: state encoding, default parameters and ring-index helpers
// shared by the jump scheduler and its round-robin arbiter.
package fsm_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_JUMP  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GUARD = 2'd3
  } sched_state_t;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_TIMEOUT      = 8;
  localparam int DEF_GUARD_CYCLES = 2;
  localparam int DEF_TW           = 4;

  // Position 'offset' steps after 'base' in a ring of 'n' entries.
  function automatic int unsigned rr_wrap(input int unsigned base,
                                          input int unsigned offset,
                                          input int unsigned n);
    return (base + offset) % n;
  endfunction

  // Entry that follows 'idx' in a ring of 'n' entries.
  function automatic int unsigned rr_next(input int unsigned idx,
                                          input int unsigned n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage

// File: rtl/fsm_jump_sched_if.sv
// fsm_jump_sched_if: requester/FSM-side signals of the jump scheduler.
// The master modport is the scheduler itself; slave is its environment.
interface fsm_jump_sched_if #(
  parameter int NUM_REQ = fsm_sched_pkg::DEF_NUM_REQ
);

  logic [NUM_REQ-1:0] req;
  logic               fsm_done;
  logic               jump;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] ack;
  logic [NUM_REQ-1:0] err;
  logic               busy;

  modport master (
    input  req,
    input  fsm_done,
    output jump,
    output grant,
    output ack,
    output err,
    output busy
  );

  modport slave (
    output req,
    output fsm_done,
    input  jump,
    input  grant,
    input  ack,
    input  err,
    input  busy
  );

endinterface

// File: rtl/fsm_jump_sched_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin pick. Starting at i_ptr and
// wrapping, the first requesting index wins; its one-hot and index are given.
module rr_arbiter
  import fsm_sched_pkg::*;
#(
  parameter int N  = DEF_NUM_REQ,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_valid
);

  // Candidate index for each search step, already wrapped around the ring.
  logic [PW-1:0] w_cand [N];

  for (genvar g = 0; g < N; g++) begin : g_cand
    assign w_cand[g] = PW'(rr_wrap(32'(i_ptr), g, N));
  end

  // Walk the candidates in priority order and keep the first requester seen.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!o_valid && i_req[w_cand[i]]) begin
        o_valid             = 1'b1;
        o_idx               = w_cand[i];
        o_grant[w_cand[i]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fsm_jump_sched.sv
// fsm_jump_sched: shares the single fsm.jump input between NUM_REQ requesters.
// One grant at a time, one jump pulse per grant, completion or timeout is
// reported to the owner, then a guard gap is enforced before the next grant.
module fsm_jump_sched
  import fsm_sched_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int TIMEOUT      = DEF_TIMEOUT,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES,
  parameter int TW           = DEF_TW
) (
  input logic              clk,
  input logic              rst_n,
  fsm_jump_sched_if.master bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Last WAIT timer value before a timeout, and last GUARD timer value.
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] GUARD_LAST   =
    TW'((GUARD_CYCLES > 0) ? (GUARD_CYCLES - 1) : 0);

  // With no guard gap a finished transaction drops straight back to IDLE.
  localparam sched_state_t POST_WAIT = (GUARD_CYCLES > 0) ? ST_GUARD : ST_IDLE;

  sched_state_t       r_state, w_state;
  logic [TW-1:0]      r_timer, w_timer;
  logic [PW-1:0]      r_ptr,   w_ptr;
  logic [NUM_REQ-1:0] r_grant, w_grant;
  logic [NUM_REQ-1:0] r_ack,   w_ack;
  logic [NUM_REQ-1:0] r_err,   w_err;
  logic               r_jump,  w_jump;
  logic               r_busy,  w_busy;

  logic [NUM_REQ-1:0] w_winOnehot;
  logic [PW-1:0]      w_winIdx;
  logic               w_winValid;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_arb (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_grant (w_winOnehot),
    .o_idx   (w_winIdx),
    .o_valid (w_winValid)
  );

  // Next-state and next-output logic; ack/err/jump default to no pulse.
  always_comb begin
    w_state = r_state;
    w_timer = r_timer;
    w_ptr   = r_ptr;
    w_grant = r_grant;
    w_ack   = '0;
    w_err   = '0;
    w_jump  = 1'b0;
    w_busy  = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_winValid) begin
          w_state = ST_JUMP;
          w_grant = w_winOnehot;
          w_jump  = 1'b1;
          w_ptr   = PW'(rr_next(32'(w_winIdx), NUM_REQ));
        end
      end

      ST_JUMP: begin
        w_state = ST_WAIT;
        w_timer = '0;
      end

      ST_WAIT: begin
        if (bus.fsm_done) begin
          w_ack   = r_grant;
          w_grant = '0;
          w_state = POST_WAIT;
          w_timer = '0;
        end else if (r_timer == TIMEOUT_LAST) begin
          w_err   = r_grant;
          w_grant = '0;
          w_state = POST_WAIT;
          w_timer = '0;
        end else begin
          w_timer = r_timer + TW'(1);
        end
      end

      ST_GUARD: begin
        if (r_timer == GUARD_LAST) begin
          w_state = ST_IDLE;
          w_timer = '0;
        end else begin
          w_timer = r_timer + TW'(1);
        end
      end

      default: begin
        w_state = ST_IDLE;
        w_grant = '0;
        w_timer = '0;
      end
    endcase

    w_busy = (w_state != ST_IDLE);
  end

  // State, timer, pointer and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_ptr   <= '0;
      r_grant <= '0;
      r_ack   <= '0;
      r_err   <= '0;
      r_jump  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_timer <= w_timer;
      r_ptr   <= w_ptr;
      r_grant <= w_grant;
      r_ack   <= w_ack;
      r_err   <= w_err;
      r_jump  <= w_jump;
      r_busy  <= w_busy;
    end
  end

  assign bus.jump  = r_jump;
  assign bus.grant = r_grant;
  assign bus.ack   = r_ack;
  assign bus.err   = r_err;
  assign bus.busy  = r_busy;

endmodule

// File: tb/tb_fsm_jump_sched.sv
// tb_fsm_jump_sched: directed scoreboard bench. Stimulus pushes the expected
// jump/ack/err events with their cycle; a monitor pops and compares them.
module tb_fsm_jump_sched;
  import fsm_sched_pkg::*;

  localparam int NR = 4;

  typedef enum int {EV_JUMP, EV_ACK, EV_ERR} ev_kind_t;

  typedef struct {
    ev_kind_t      kind;
    logic [NR-1:0] val;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cycle = 0;
  int   assertCount = 0;
  int   failCount = 0;
  exp_t expQ[$];

  fsm_jump_sched_if #(.NUM_REQ(NR)) bus ();

  fsm_jump_sched #(
    .NUM_REQ      (NR),
    .TIMEOUT      (8),
    .GUARD_CYCLES (2),
    .TW           (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic applyStimulus(input logic [NR-1:0] r, input logic d, input logic rn);
    bus.req      = r;
    bus.fsm_done = d;
    rst_n        = rn;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic pushExp(input ev_kind_t k, input logic [NR-1:0] v, input int c);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.cyc  = c;
    expQ.push_back(e);
  endtask

  task automatic waitUntil(input int t);
    while (cycle < t) @(negedge clk);
  endtask

  function automatic logic [31:0] allOutputs();
    return 32'({bus.jump, bus.grant, bus.ack, bus.err, bus.busy});
  endfunction

  task automatic popCompare(input ev_kind_t k, input logic [NR-1:0] v);
    exp_t e;
    assertCount++;
    if (expQ.size() == 0) begin
      failCount++;
      $display("[TB] FAIL unexpected_%s: got %b at cycle %0d, required no event", k.name(), v, cycle);
    end else begin
      e = expQ.pop_front();
      if (e.kind != k || e.val !== v || e.cyc != cycle) begin
        failCount++;
        $display("[TB] FAIL event_%s: got %s=%b at cycle %0d, required %s=%b at cycle %0d",
                 e.kind.name(), k.name(), v, cycle, e.kind.name(), e.val, e.cyc);
      end
    end
  endtask

  // Monitor: every jump, ack or err pulse must match the head of the queue.
  always @(negedge clk) begin
    if (bus.jump === 1'b1) popCompare(EV_JUMP, bus.grant);
    if (bus.ack != '0)     popCompare(EV_ACK, bus.ack);
    if (bus.err != '0)     popCompare(EV_ERR, bus.err);
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run still active at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    logic [NR-1:0] fairOwner [5];
    logic [NR-1:0] held;

    fairOwner = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010};

    // Reset held with every request and fsm_done asserted.
    applyStimulus(4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("reset_outputs", allOutputs(), 32'd0);
    end

    // Release: requester 0 wins first; done seen in the first WAIT cycle.
    c = cycle;
    applyStimulus(4'b1111, 1'b0, 1'b1);
    pushExp(EV_JUMP, 4'b0001, c + 1);
    pushExp(EV_ACK,  4'b0001, c + 3);
    waitUntil(c + 1); checkOutput("first_grant_busy", 32'(bus.busy), 32'd1);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    waitUntil(c + 2); applyStimulus(4'b0000, 1'b1, 1'b1);
    waitUntil(c + 3); applyStimulus(4'b0000, 1'b0, 1'b1);
    waitUntil(c + 5); checkOutput("idle_after_guard_busy", 32'(bus.busy), 32'd0);

    // Single request, done 3 cycles after the jump.
    c = cycle;
    applyStimulus(4'b0100, 1'b0, 1'b1);
    pushExp(EV_JUMP, 4'b0100, c + 1);
    pushExp(EV_ACK,  4'b0100, c + 5);
    waitUntil(c + 1); applyStimulus(4'b0000, 1'b0, 1'b1);
    waitUntil(c + 2); checkOutput("single_jump_one_cycle", 32'(bus.jump), 32'd0);
    waitUntil(c + 3); checkOutput("single_grant_held", 32'(bus.grant), 32'(4'b0100));
    waitUntil(c + 4); applyStimulus(4'b0000, 1'b1, 1'b1);
    waitUntil(c + 5); applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("single_grant_cleared", 32'(bus.grant), 32'd0);
    waitUntil(c + 6); checkOutput("single_busy_guard", 32'(bus.busy), 32'd1);
    waitUntil(c + 7); checkOutput("single_busy_fall", 32'(bus.busy), 32'd0);

    // Short reset so the fairness run starts from pointer 0.
    applyStimulus(4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("reset_pulse_outputs", allOutputs(), 32'd0);

    // Fairness: 1011 held, done one cycle after each jump.
    c = cycle;
    held = 4'b1011;
    applyStimulus(held, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      pushExp(EV_JUMP, fairOwner[k], c + 1 + 5 * k);
      pushExp(EV_ACK,  fairOwner[k], c + 3 + 5 * k);
    end
    for (int k = 0; k < 5; k++) begin
      waitUntil(c + 1 + 5 * k);
      if (k == 4) held = 4'b0000;
      applyStimulus(held, 1'b0, 1'b1);
      waitUntil(c + 2 + 5 * k); applyStimulus(held, 1'b1, 1'b1);
      waitUntil(c + 3 + 5 * k); applyStimulus(held, 1'b0, 1'b1);
    end
    waitUntil(c + 25);

    // Timeout with request held, then a new grant after the guard gap.
    c = cycle;
    applyStimulus(4'b0010, 1'b0, 1'b1);
    pushExp(EV_JUMP, 4'b0010, c + 1);
    pushExp(EV_ERR,  4'b0010, c + 10);
    pushExp(EV_JUMP, 4'b0010, c + 13);
    pushExp(EV_ACK,  4'b0010, c + 15);
    waitUntil(c + 9);  checkOutput("timeout_grant_last_wait", 32'(bus.grant), 32'(4'b0010));
    waitUntil(c + 10); checkOutput("timeout_grant_cleared", 32'(bus.grant), 32'd0);
    checkOutput("timeout_busy_guard", 32'(bus.busy), 32'd1);
    waitUntil(c + 13); applyStimulus(4'b0000, 1'b0, 1'b1);
    waitUntil(c + 14); applyStimulus(4'b0000, 1'b1, 1'b1);
    waitUntil(c + 15); applyStimulus(4'b0000, 1'b0, 1'b1);
    waitUntil(c + 17);

    // Done arrives exactly in the eighth WAIT cycle: ack wins over err.
    c = cycle;
    applyStimulus(4'b0100, 1'b0, 1'b1);
    pushExp(EV_JUMP, 4'b0100, c + 1);
    pushExp(EV_ACK,  4'b0100, c + 10);
    waitUntil(c + 1);  applyStimulus(4'b0000, 1'b0, 1'b1);
    waitUntil(c + 9);  applyStimulus(4'b0000, 1'b1, 1'b1);
    waitUntil(c + 10); applyStimulus(4'b0000, 1'b0, 1'b1);
    waitUntil(c + 12);

    // Done only during the JUMP cycle is ignored, so the owner times out.
    c = cycle;
    applyStimulus(4'b1000, 1'b0, 1'b1);
    pushExp(EV_JUMP, 4'b1000, c + 1);
    pushExp(EV_ERR,  4'b1000, c + 10);
    waitUntil(c + 1); applyStimulus(4'b0000, 1'b1, 1'b1);
    waitUntil(c + 2); applyStimulus(4'b0000, 1'b0, 1'b1);
    waitUntil(c + 12);

    // Reset in WAIT cycle 3: no ack/err, and the pointer restarts at 0.
    c = cycle;
    applyStimulus(4'b0010, 1'b0, 1'b1);
    pushExp(EV_JUMP, 4'b0010, c + 1);
    waitUntil(c + 1); applyStimulus(4'b0000, 1'b0, 1'b1);
    waitUntil(c + 4); applyStimulus(4'b0000, 1'b0, 1'b0);
    waitUntil(c + 5); checkOutput("midwait_reset_outputs", allOutputs(), 32'd0);
    applyStimulus(4'b1001, 1'b0, 1'b1);
    pushExp(EV_JUMP, 4'b0001, c + 6);
    pushExp(EV_ACK,  4'b0001, c + 8);
    waitUntil(c + 6); applyStimulus(4'b0000, 1'b0, 1'b1);
    waitUntil(c + 7); applyStimulus(4'b0000, 1'b1, 1'b1);
    waitUntil(c + 8); applyStimulus(4'b0000, 1'b0, 1'b1);
    waitUntil(c + 12);

    // Every expected event must have been observed.
    assertCount++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL pending_events: got %0d unseen expected events, required 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
